// File: rtl/wb_commit_stage.sv
// Purpose : MEM/WB consumer; buffers one beat, commits it to a 32-entry register file and exposes it for EX forwarding.
// Latency : a beat accepted at edge N commits at edge N+1 unless held. With bypass it is readable from N+1, otherwise from N+2.
// Backpres: ready_o drops while the buffered beat is held, and for any cycle with pipeline_flush asserted.
//
// Ports:
//   clk_i, reset_i                 clock (rising edge) and synchronous active-high reset
//   pipeline_flush                 drops the buffered beat and refuses input this cycle
//   valid_i / ready_o              MEM/WB handshake
//   mem_data_i, mem_address_i      load data and ALU result; MemToReg_i selects between them
//   rd_i, RegWrite_i               destination register and its write enable
//   hold_i                         blocks the commit
//   rs1_/rs2_addr_i, rs1_/rs2_data_o   combinational decode read ports (x0 reads 0)
//   fwd_valid_o, fwd_rd_o, fwd_data_o  describe the pending write of the buffered beat
//
// Optional feature, enabled by the macro WB_RETIRE_COUNTER_EN:
//   retire_count_o [63:0]          free-running count of commits; wraps to 0
//   retire_pulse_o                 high in each commit cycle
module wb_commit_stage #(
    parameter int DataWidth        = 32,
    parameter bit ClearRegsOnReset = 1'b1,
    parameter bit BypassReads      = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 pipeline_flush,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] mem_data_i,
    input  logic [DataWidth-1:0] mem_address_i,
    input  logic [4:0]           rd_i,
    input  logic                 RegWrite_i,
    input  logic                 MemToReg_i,
    input  logic                 hold_i,
    input  logic [4:0]           rs1_addr_i,
    input  logic [4:0]           rs2_addr_i,
    output logic [DataWidth-1:0] rs1_data_o,
    output logic [DataWidth-1:0] rs2_data_o,
    output logic                 fwd_valid_o,
    output logic [4:0]           fwd_rd_o,
    output logic [DataWidth-1:0] fwd_data_o
`ifdef WB_RETIRE_COUNTER_EN
    ,
    output logic [63:0]          retire_count_o,
    output logic                 retire_pulse_o
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           rd_q;
    logic                 we_q;
    logic [DataWidth-1:0] wbval_q;
    logic [DataWidth-1:0] regs [0:31];

    logic commit;
    logic commit_we;
    logic accept;

    // Handshake and next-state logic
    always_comb begin
        commit    = (state_q == FULL) && !hold_i && !pipeline_flush;
        commit_we = commit && we_q && (rd_q != 5'd0);
        ready_o   = !pipeline_flush && ((state_q == EMPTY) || commit);
        accept    = valid_i && ready_o;
        state_d   = state_q;
        if (pipeline_flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = FULL;
        end else if (commit) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= EMPTY;
            rd_q    <= '0;
            we_q    <= 1'b0;
            wbval_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_q    <= rd_i;
                we_q    <= RegWrite_i;
                wbval_q <= MemToReg_i ? mem_data_i : mem_address_i;
            end
        end
    end

    // Register file. Reset takes priority, so a beat still buffered when
    // reset arrives is dropped without being written.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            if (ClearRegsOnReset) begin
                for (int i = 0; i < 32; i++) begin
                    regs[i] <= '0;
                end
            end
        end else if (commit_we) begin
            regs[rd_q] <= wbval_q;
        end
    end

    // Read ports. Entry 0 is never written, but it is forced to zero here so
    // that x0 also reads 0 when registers are not cleared on reset.
    always_comb begin
        rs1_data_o = regs[rs1_addr_i];
        rs2_data_o = regs[rs2_addr_i];
        if (BypassReads && commit_we && (rd_q == rs1_addr_i)) begin
            rs1_data_o = wbval_q;
        end
        if (BypassReads && commit_we && (rd_q == rs2_addr_i)) begin
            rs2_data_o = wbval_q;
        end
        if (rs1_addr_i == 5'd0) begin
            rs1_data_o = '0;
        end
        if (rs2_addr_i == 5'd0) begin
            rs2_data_o = '0;
        end
    end

    // Forwarding stays valid for as long as the beat is held in the buffer.
    always_comb begin
        fwd_valid_o = (state_q == FULL) && we_q && (rd_q != 5'd0);
        fwd_rd_o    = rd_q;
        fwd_data_o  = wbval_q;
    end

`ifdef WB_RETIRE_COUNTER_EN
    // Counts every commit, including commits that write nothing.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            retire_count_o <= '0;
        end else if (commit) begin
            retire_count_o <= retire_count_o + 64'd1;
        end
    end

    always_comb begin
        retire_pulse_o = commit;
    end
`endif

endmodule
